// File: rtl/jtopll_chreg_if.sv
// CPU-side bus of the OPLL channel register file: channel write handshake
// plus the user-patch byte write strobe.
interface jtopll_chreg_if;
  logic       wr_req;
  logic [3:0] wr_ch;
  logic [1:0] wr_reg;
  logic [7:0] wr_din;
  logic       wr_busy;
  logic       wr_done;
  logic       up_patch;
  logic [2:0] patch_idx;
  logic [2:0] patch_byte;

  modport master (
    output wr_req, wr_ch, wr_reg, wr_din, up_patch, patch_idx, patch_byte,
    input  wr_busy, wr_done
  );

  modport slave (
    input  wr_req, wr_ch, wr_reg, wr_din, up_patch, patch_idx, patch_byte,
    output wr_busy, wr_done
  );
endinterface

// File: rtl/jtopll_chreg.sv
// Time-multiplexed OPLL channel register file: walks two operator slots per
// channel, commits CPU writes on the owning carrier slot, hosts user patches.
module jtopll_chreg #(
  parameter int CH     = 9,
  parameter int NUSER  = 1,
  parameter int FNUMW  = 9,
  parameter int BLOCKW = 3
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              cen,
  jtopll_chreg_if.slave     cpu,
  output logic [3:0]        rom_addr,
  input  logic [63:0]       rom_data,
  output logic              zero,
  output logic              op,
  output logic [3:0]        ch,
  output logic [FNUMW-1:0]  fnum_I,
  output logic [BLOCKW-1:0] block_I,
  output logic              keyon_I,
  output logic              sus_I,
  output logic [3:0]        vol_I,
  output logic [3:0]        inst_I,
  output logic              kon_rise_I,
  output logic [63:0]       patch_I
);
  localparam int SW = $clog2(2*CH);
  localparam int UW = (NUSER > 1) ? $clog2(NUSER) : 1;
  localparam logic [SW-1:0]    LAST    = SW'(2*CH-1);
  localparam logic [FNUMW-1:0] HI_MASK = FNUMW'(2'b11) << 9;

  logic [SW-1:0]     r_slot;
  logic [FNUMW-1:0]  r_fnum  [CH];
  logic [BLOCKW-1:0] r_block [CH];
  logic [3:0]        r_vol   [CH];
  logic [3:0]        r_inst  [CH];
  logic [CH-1:0]     r_kon;
  logic [CH-1:0]     r_sus;
  logic [CH-1:0]     r_last_kon;
  logic [63:0]       r_user  [NUSER];
  logic              r_busy;
  logic              r_done;
  logic [3:0]        r_pch;
  logic [1:0]        r_preg;
  logic [7:0]        r_pdin;

  logic [3:0]        w_ch;
  logic              w_op;
  logic              w_real;
  logic [SW-1:0]     w_tgt;
  logic              w_commit;
  logic [FNUMW-1:0]  w_fnum_new;

  assign w_ch   = 4'(r_slot >> 1);
  assign w_op   = r_slot[0];
  // Writes that cannot land on a real field retire on the last slot instead.
  assign w_real   = (32'(r_pch) < CH) && (r_preg != 2'd3);
  assign w_tgt    = w_real ? SW'({r_pch, 1'b1}) : LAST;
  assign w_commit = cen & r_busy & (r_slot == w_tgt);

  // Merge the pending byte into the target channel's current fnum.
  always_comb begin
    w_fnum_new = r_fnum[r_pch];
    case (r_preg)
      2'd0: w_fnum_new[7:0] = r_pdin;
      2'd1: begin
        w_fnum_new[8] = r_pdin[0];
        w_fnum_new    = (w_fnum_new & ~HI_MASK) | ((FNUMW'(r_pdin[7:6]) << 9) & HI_MASK);
      end
      default: w_fnum_new = r_fnum[r_pch];
    endcase
  end

  // Slot counter, two operator slots per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
    end else if (cen) begin
      r_slot <= (r_slot == LAST) ? '0 : r_slot + SW'(1);
    end
  end

  // Single-entry write handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pch  <= 4'd0;
      r_preg <= 2'd0;
      r_pdin <= 8'd0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        r_busy <= 1'b0;
      end else if (!r_busy && cpu.wr_req) begin
        r_busy <= 1'b1;
        r_pch  <= cpu.wr_ch;
        r_preg <= cpu.wr_reg;
        r_pdin <= cpu.wr_din;
      end
    end
  end

  // Channel CSRs; last_kon samples the pre-commit key-on of the carrier slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kon      <= '0;
      r_sus      <= '0;
      r_last_kon <= '0;
      for (int i = 0; i < CH; i++) begin
        r_fnum[i]  <= '0;
        r_block[i] <= '0;
        r_vol[i]   <= 4'd0;
        r_inst[i]  <= 4'd0;
      end
    end else begin
      if (cen && w_op) begin
        r_last_kon[w_ch] <= r_kon[w_ch];
      end
      if (w_commit && w_real) begin
        case (r_preg)
          2'd0: r_fnum[r_pch] <= w_fnum_new;
          2'd1: begin
            r_fnum[r_pch]  <= w_fnum_new;
            r_block[r_pch] <= r_pdin[1 +: BLOCKW];
            r_kon[r_pch]   <= r_pdin[BLOCKW+1];
            r_sus[r_pch]   <= r_pdin[BLOCKW+2];
          end
          2'd2: begin
            r_inst[r_pch] <= r_pdin[7:4];
            r_vol[r_pch]  <= r_pdin[3:0];
          end
          default: r_fnum[r_pch] <= r_fnum[r_pch];
        endcase
      end
    end
  end

  // User patch bytes are written immediately, independent of cen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUSER; i++) begin
        r_user[i] <= 64'd0;
      end
    end else if (cpu.up_patch && (32'(cpu.patch_idx) < NUSER)) begin
      r_user[cpu.patch_idx[UW-1:0]][{cpu.patch_byte, 3'b000} +: 8] <= cpu.wr_din;
    end
  end

  assign ch          = w_ch;
  assign op          = w_op;
  assign zero        = (r_slot == '0);
  assign fnum_I      = r_fnum[w_ch];
  assign block_I     = r_block[w_ch];
  assign keyon_I     = r_kon[w_ch];
  assign sus_I       = r_sus[w_ch];
  assign vol_I       = r_vol[w_ch];
  assign inst_I      = r_inst[w_ch];
  assign kon_rise_I  = ~w_op & r_kon[w_ch] & ~r_last_kon[w_ch];
  assign rom_addr    = r_inst[w_ch];
  assign patch_I     = (32'(inst_I) < NUSER) ? r_user[inst_I[UW-1:0]] : rom_data;
  assign cpu.wr_busy = r_busy;
  assign cpu.wr_done = r_done;
endmodule

// File: tb/tb_jtopll_chreg.sv
// Bench for jtopll_chreg: directed scenarios then random traffic, all checked
// every clock against a slot-level reference model.
module tb_jtopll_chreg;
  localparam int CH    = 9;
  localparam int NUSER = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [3:0]  rom_addr;
  logic [63:0] rom_data;
  logic        zero, op, keyon_I, sus_I, kon_rise_I;
  logic [3:0]  ch, vol_I, inst_I;
  logic [8:0]  fnum_I;
  logic [2:0]  block_I;
  logic [63:0] patch_I;

  jtopll_chreg_if bus();

  jtopll_chreg #(.CH(CH), .NUSER(NUSER), .FNUMW(9), .BLOCKW(3)) dut (
    .rst(rst), .clk(clk), .cen(cen), .cpu(bus),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .zero(zero), .op(op), .ch(ch), .fnum_I(fnum_I), .block_I(block_I),
    .keyon_I(keyon_I), .sus_I(sus_I), .vol_I(vol_I), .inst_I(inst_I),
    .kon_rise_I(kon_rise_I), .patch_I(patch_I)
  );

  always #5 clk = ~clk;
  assign rom_data = {8{4'hA, rom_addr}};

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          m_s;
  logic [8:0]  m_fnum [16];
  logic [2:0]  m_block[16];
  logic        m_kon  [16];
  logic        m_sus  [16];
  logic        m_last [16];
  logic [3:0]  m_vol  [16];
  logic [3:0]  m_inst [16];
  logic [63:0] m_user [8];
  logic        m_busy, m_done;
  int          m_pch, m_preg;
  logic [7:0]  m_pdin;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_busy = 1'b0; m_done = 1'b0;
    m_pch = 0; m_preg = 0; m_pdin = 8'd0;
    for (int i = 0; i < 16; i++) begin
      m_fnum[i] = 9'd0; m_block[i] = 3'd0; m_kon[i] = 1'b0; m_sus[i] = 1'b0;
      m_last[i] = 1'b0; m_vol[i] = 4'd0; m_inst[i] = 4'd0;
    end
    for (int i = 0; i < 8; i++) m_user[i] = 64'd0;
  endtask

  task automatic model_step();
    int  tgt;
    bit  commit;
    if (rst) begin
      model_reset();
    end else begin
      tgt    = (m_pch < CH && m_preg != 3) ? 2*m_pch + 1 : 2*CH - 1;
      commit = cen && m_busy && (m_s == tgt);
      m_done = commit;
      if (cen && (m_s % 2 == 1)) m_last[m_s/2] = m_kon[m_s/2];
      if (commit && m_pch < CH) begin
        if (m_preg == 0) m_fnum[m_pch][7:0] = m_pdin;
        if (m_preg == 1) begin
          m_fnum[m_pch][8] = m_pdin[0];
          m_block[m_pch]   = m_pdin[3:1];
          m_kon[m_pch]     = m_pdin[4];
          m_sus[m_pch]     = m_pdin[5];
        end
        if (m_preg == 2) begin
          m_inst[m_pch] = m_pdin[7:4];
          m_vol[m_pch]  = m_pdin[3:0];
        end
      end
      if (commit) m_busy = 1'b0;
      else if (!m_busy && bus.wr_req) begin
        m_busy = 1'b1; m_pch = bus.wr_ch; m_preg = bus.wr_reg; m_pdin = bus.wr_din;
      end
      if (bus.up_patch && bus.patch_idx < NUSER)
        m_user[bus.patch_idx][8*bus.patch_byte +: 8] = bus.wr_din;
      if (cen) m_s = (m_s + 1) % (2*CH);
    end
  endtask

  task automatic check_all();
    int c;
    logic [63:0] pe;
    c  = m_s / 2;
    pe = (m_inst[c] < NUSER) ? m_user[m_inst[c]] : {8{4'hA, m_inst[c]}};
    chk("wr_busy", bus.wr_busy, m_busy);
    chk("wr_done", bus.wr_done, m_done);
    chk("zero", zero, m_s == 0);
    chk("op", op, m_s % 2);
    chk("ch", ch, c);
    chk("fnum", fnum_I, m_fnum[c]);
    chk("block", block_I, m_block[c]);
    chk("keyon", keyon_I, m_kon[c]);
    chk("sus", sus_I, m_sus[c]);
    chk("vol", vol_I, m_vol[c]);
    chk("inst", inst_I, m_inst[c]);
    chk("kon_rise", kon_rise_I, (m_s % 2 == 0) && m_kon[c] && !m_last[c]);
    chk("rom_addr", rom_addr, m_inst[c]);
    chk("patch", patch_I, pe);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run_to(input int c, input int o);
    for (int i = 0; i < 200 && m_s != 2*c + o; i++) tick();
    chk("run_to_slot", dut.r_slot, 2*c + o);
  endtask

  task automatic cpu_write(input logic [3:0] c, input logic [1:0] r, input logic [7:0] d);
    for (int i = 0; i < 200 && m_busy; i++) tick();
    bus.wr_ch = c; bus.wr_reg = r; bus.wr_din = d; bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    for (int i = 0; i < 200 && !bus.wr_done; i++) tick();
    chk("wr_done_seen", bus.wr_done, 1'b1);
  endtask

  initial begin
    int nz, lat, ncen, rises, done_seen, k;
    rst = 1'b1; cen = 1'b1;
    bus.wr_req = 1'b0; bus.wr_ch = 4'd0; bus.wr_reg = 2'd0; bus.wr_din = 8'd0;
    bus.up_patch = 1'b0; bus.patch_idx = 3'd0; bus.patch_byte = 3'd0;
    model_reset();
    #1; check_all();
    tick(); tick();
    rst = 1'b0;

    // free-running slot walk: zero every 18 clocks
    nz = 0;
    for (int i = 0; i < 36; i++) begin tick(); if (zero) nz++; end
    chk("zero_pulses", nz, 2);

    // write ch3 fnum low from s=0, second request while busy is dropped
    for (int i = 0; i < 40 && m_s != 0; i++) tick();
    bus.wr_ch = 4'd3; bus.wr_reg = 2'd0; bus.wr_din = 8'hA5; bus.wr_req = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); lat++;
      bus.wr_req = (i == 2);
      if (i == 2) begin bus.wr_ch = 4'd4; bus.wr_din = 8'h55; end
      if (bus.wr_done) break;
    end
    bus.wr_req = 1'b0;
    chk("lat_cen1", lat, 8);
    run_to(3, 0); chk("fnum_ch3", fnum_I, 9'h0A5);
    run_to(4, 0); chk("fnum_ch4", fnum_I, 9'h000);

    // key-on via reg1, single rising edge
    cpu_write(4'd2, 2'd1, 8'b0001_0101);
    rises = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (kon_rise_I && ch == 4'd2) rises++; end
    chk("kon_rises", rises, 1);
    run_to(2, 1); chk("block_ch2", block_I, 3'd2); chk("fnum8_ch2", fnum_I[8], 1'b1);

    // user patch then ROM patch
    bus.up_patch = 1'b1; bus.patch_idx = 3'd0;
    for (int b = 0; b < 8; b++) begin
      bus.patch_byte = 3'(b); bus.wr_din = 8'(8'h11 * (b + 1));
      tick();
    end
    bus.up_patch = 1'b0;
    cpu_write(4'd0, 2'd2, 8'h0F);
    run_to(0, 0); chk("user_patch", patch_I, 64'h8877665544332211);
    cpu_write(4'd0, 2'd2, 8'h3F);
    run_to(0, 0); chk("rom_addr3", rom_addr, 4'd3); chk("rom_patch", patch_I, {8{8'hA3}});

    // gated clock enable: latency counted in cen ticks
    k = 0;
    while (!(m_s == 0 && (k % 4) == 0) && k < 400) begin cen = (k % 4 == 0); tick(); k++; end
    bus.wr_ch = 4'd3; bus.wr_reg = 2'd2; bus.wr_din = 8'h27; bus.wr_req = 1'b1;
    ncen = 0;
    for (int i = 0; i < 200; i++) begin
      cen = (k % 4 == 0); tick(); bus.wr_req = 1'b0;
      if (cen) ncen++;
      k++;
      if (bus.wr_done) break;
    end
    chk("lat_gated", ncen, 8);
    cen = 1'b1;

    // async reset while a write is pending
    for (int i = 0; i < 40 && m_s != 0; i++) tick();
    bus.wr_ch = 4'd5; bus.wr_reg = 2'd0; bus.wr_din = 8'hFF; bus.wr_req = 1'b1;
    tick(); bus.wr_req = 1'b0;
    tick(); tick(); tick();
    chk("busy_pre_rst", bus.wr_busy, 1'b1);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.wr_done) done_seen++; end
    chk("no_done_after_rst", done_seen, 0);
    run_to(5, 0); chk("fnum_ch5_after_rst", fnum_I, 9'h000);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cen          = ($urandom % 3) != 0;
      bus.wr_req   = ($urandom % 4) == 0;
      bus.wr_ch    = ($urandom % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, CH-1));
      bus.wr_reg   = 2'($urandom_range(0, 3));
      bus.wr_din   = 8'($urandom);
      bus.up_patch = ($urandom % 8) == 0;
      bus.patch_idx  = 3'($urandom_range(0, 7));
      bus.patch_byte = 3'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
